// File: rtl/lpc_pkg.sv
// lpc_pkg: shared states, bus codes and status encodings for the LPC cycle decoder
package lpc_pkg;
  typedef enum logic [2:0] {IDLE, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2} lpc_state_t;
  typedef enum logic [2:0] {ST_OK, ST_SYNC_ERR, ST_TIMEOUT, ST_ABORT, ST_PROTO} lpc_status_t;
  localparam logic [1:0] CT_IO = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG = 4'b0110;
  localparam logic [3:0] SYNC_ERR = 4'b1010;
  localparam logic [3:0] START_CODE = 4'b0000;
  localparam logic [3:0] START_ABORT = 4'b1111;
endpackage

// File: rtl/lpc_if.sv
// lpc_if: LPC pin bundle plus the decoded-cycle report fields
interface lpc_if #(parameter int WAIT_CNT_W = 5);
  logic [3:0] lpc_ad;
  logic lpc_frame;
  logic out_valid;
  logic [3:0] out_cyctype_dir;
  logic [31:0] out_addr;
  logic [7:0] out_data;
  logic [2:0] out_status;
  logic [WAIT_CNT_W-1:0] out_waits;
  modport master (output lpc_ad, lpc_frame,
                  input out_valid, out_cyctype_dir, out_addr, out_data, out_status, out_waits);
  modport slave (input lpc_ad, lpc_frame,
                 output out_valid, out_cyctype_dir, out_addr, out_data, out_status, out_waits);
endinterface

// File: rtl/lpc_sync_tracker.sv
// lpc_sync_tracker: counts SYNC wait nibbles and classifies the terminating SYNC nibble
module lpc_sync_tracker import lpc_pkg::*; #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_CNT_W = 5
) (
  input  logic lpc_clock,
  input  logic lpc_reset,
  input  logic clr,
  input  logic en,
  input  logic [3:0] ad,
  output logic done,
  output lpc_status_t status,
  output logic [WAIT_CNT_W-1:0] waits
);
  logic is_wait, at_max;
  assign is_wait = ad == SYNC_SHORT || ad == SYNC_LONG;
  assign at_max = waits == WAIT_CNT_W'(WAIT_MAX);
  // a wait nibble beyond WAIT_MAX terminates the cycle instead of counting
  assign done = en && (!is_wait || at_max);
  assign status = is_wait ? ST_TIMEOUT : ad == SYNC_READY ? ST_OK : ad == SYNC_ERR ? ST_SYNC_ERR : ST_PROTO;
  always_ff @(negedge lpc_clock or negedge lpc_reset)
    if (!lpc_reset) waits <= '0;
    else if (clr) waits <= '0;
    else if (en && is_wait && !at_max) waits <= waits + 1'b1;
endmodule

// File: rtl/lpc_cycle_decoder.sv
// lpc_cycle_decoder: snoops LPC I/O and memory cycles and reports each one with a status pulse
module lpc_cycle_decoder import lpc_pkg::*; #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_CNT_W = 5,
  parameter bit REPORT_ABORT = 1'b1
) (
  input logic lpc_clock,
  input logic lpc_reset,
  lpc_if.slave bus
);
  lpc_state_t state;
  lpc_status_t rstat, trk_status;
  logic [3:0] ctd;
  logic [31:0] addr;
  logic [7:0] data;
  logic [2:0] cnt;
  logic pend, trk_done, is_write, last_addr, in_cycle;
  logic [WAIT_CNT_W-1:0] trk_waits;
  assign is_write = ctd[1];
  assign last_addr = cnt == (ctd[3:2] == CT_IO ? 3'd3 : 3'd7);
  assign in_cycle = state inside {ADDR, WDATA, TAR1, SYNC, RDATA};
  lpc_sync_tracker #(.WAIT_MAX(WAIT_MAX), .WAIT_CNT_W(WAIT_CNT_W)) u_sync (
    .lpc_clock(lpc_clock),
    .lpc_reset(lpc_reset),
    .clr(state == CYCTYPE || state == TAR1),
    .en(bus.lpc_frame && state == SYNC),
    .ad(bus.lpc_ad),
    .done(trk_done),
    .status(trk_status),
    .waits(trk_waits)
  );
  // reports are staged in pend and published one clock later, so a START on that clock cannot drop them
  always_ff @(negedge lpc_clock or negedge lpc_reset)
    if (!lpc_reset) begin
      state <= IDLE;
      rstat <= ST_OK;
      ctd <= '0;
      addr <= '0;
      data <= '0;
      cnt <= '0;
      pend <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_cyctype_dir <= '0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      bus.out_status <= '0;
      bus.out_waits <= '0;
    end else begin
      bus.out_valid <= pend;
      if (pend) begin
        bus.out_cyctype_dir <= ctd;
        bus.out_addr <= addr;
        bus.out_data <= rstat inside {ST_OK, ST_SYNC_ERR} ? data : 8'h00;
        bus.out_status <= rstat;
        bus.out_waits <= trk_waits;
      end
      pend <= 1'b0;
      if (!bus.lpc_frame) begin
        state <= bus.lpc_ad == START_CODE ? CYCTYPE : IDLE;
        if (REPORT_ABORT && bus.lpc_ad == START_ABORT && in_cycle) begin
          pend <= 1'b1;
          rstat <= ST_ABORT;
        end
      end else
        case (state)
          CYCTYPE: begin
            ctd <= bus.lpc_ad;
            addr <= '0;
            data <= '0;
            cnt <= '0;
            state <= bus.lpc_ad[3:2] inside {CT_IO, CT_MEM} ? ADDR : IDLE;
          end
          ADDR: begin
            addr <= {addr[27:0], bus.lpc_ad};
            cnt <= last_addr ? 3'd0 : cnt + 3'd1;
            if (last_addr) state <= is_write ? WDATA : TAR1;
          end
          WDATA, RDATA: begin
            data <= {bus.lpc_ad, data[7:4]};
            cnt <= cnt[0] ? 3'd0 : cnt + 3'd1;
            pend <= cnt[0] && state == RDATA;
            if (cnt[0]) state <= state == WDATA ? TAR1 : TAR2;
          end
          TAR1, TAR2: begin
            cnt <= cnt[0] ? 3'd0 : cnt + 3'd1;
            if (cnt[0]) state <= state == TAR1 ? SYNC : IDLE;
          end
          SYNC: if (trk_done) begin
            rstat <= trk_status;
            if (trk_status inside {ST_OK, ST_SYNC_ERR}) begin
              state <= is_write ? TAR2 : RDATA;
              pend <= is_write;
            end else begin
              state <= IDLE;
              pend <= 1'b1;
            end
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// tb_lpc_cycle_decoder: scoreboard bench driving two decoders (abort reporting on and off)
module tb_lpc_cycle_decoder;
  typedef struct {
    logic [3:0] ctd;
    logic [31:0] addr;
    logic [7:0] data;
    logic [2:0] st;
    logic [4:0] waits;
    int due;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, frame = 1'b1;
  logic [3:0] ad = 4'hF;
  int cyc = 0, tests = 0, fails = 0;
  exp_t q1[$], q0[$];

  lpc_if #(.WAIT_CNT_W(5)) b1 ();
  lpc_if #(.WAIT_CNT_W(5)) b0 ();
  assign b1.lpc_ad = ad;
  assign b1.lpc_frame = frame;
  assign b0.lpc_ad = ad;
  assign b0.lpc_frame = frame;

  lpc_cycle_decoder #(.WAIT_MAX(16), .WAIT_CNT_W(5), .REPORT_ABORT(1'b1)) dut1 (
    .lpc_clock(clk), .lpc_reset(rst_n), .bus(b1.slave));
  lpc_cycle_decoder #(.WAIT_MAX(16), .WAIT_CNT_W(5), .REPORT_ABORT(1'b0)) dut0 (
    .lpc_clock(clk), .lpc_reset(rst_n), .bus(b0.slave));

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic f, input logic [3:0] a);
    @(posedge clk);
    frame = f;
    ad = a;
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d,
                      input logic [2:0] s, input logic [4:0] w, input bit to0);
    exp_t e;
    e = '{c, a, d, s, w, cyc + 2};
    q1.push_back(e);
    if (to0) q0.push_back(e);
  endtask

  task automatic nibs(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) nib(1'b1, v[i*4 +: 4]);
  endtask

  task automatic head(input logic [3:0] ct, input logic [31:0] a, input int n);
    nib(1'b0, 4'h0);
    nib(1'b1, ct);
    nibs(a, n);
  endtask

  always @(posedge clk) if (b1.out_valid) begin : mon1
    exp_t e;
    if (q1.size() == 0) check("r1_extra_pulse", 1, 0);
    else begin
      e = q1.pop_front();
      check("r1_cyctype", b1.out_cyctype_dir, e.ctd);
      check("r1_addr", b1.out_addr, e.addr);
      check("r1_data", b1.out_data, e.data);
      check("r1_status", b1.out_status, e.st);
      check("r1_waits", b1.out_waits, e.waits);
      check("r1_latency", cyc, e.due);
    end
  end

  always @(posedge clk) if (b0.out_valid) begin : mon0
    exp_t e;
    if (q0.size() == 0) check("r0_extra_pulse", 1, 0);
    else begin
      e = q0.pop_front();
      check("r0_addr", b0.out_addr, e.addr);
      check("r0_status", b0.out_status, e.st);
      check("r0_latency", cyc, e.due);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, b1.out_valid, 0);
    check({tag, "_cyctype"}, b1.out_cyctype_dir, 0);
    check({tag, "_addr"}, b1.out_addr, 0);
    check({tag, "_data"}, b1.out_data, 0);
    check({tag, "_status"}, b1.out_status, 0);
    check({tag, "_waits"}, b1.out_waits, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    nib(1'b1, 4'hF);
    // I/O write 0x0080 <- 0xA5, with a repeated START
    nib(1'b0, 4'h0);
    head(4'b0010, 32'h0080, 4);
    nib(1'b1, 4'h5); nib(1'b1, 4'hA);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    nib(1'b1, 4'h0); push(4'b0010, 32'h80, 8'hA5, 3'd0, 5'd0, 1'b1);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // memory read 0xFFFFFFF0, 3 short waits
    head(4'b0100, 32'hFFFFFFF0, 8);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    repeat (3) nib(1'b1, 4'h5);
    nib(1'b1, 4'h0);
    nib(1'b1, 4'h3); nib(1'b1, 4'hC); push(4'b0100, 32'hFFFFFFF0, 8'hC3, 3'd0, 5'd3, 1'b1);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // I/O read timing out after WAIT_MAX+1 long waits
    head(4'b0000, 32'h0060, 4);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    repeat (16) nib(1'b1, 4'h6);
    nib(1'b1, 4'h6); push(4'b0000, 32'h60, 8'h00, 3'd2, 5'd16, 1'b1);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // I/O write with SYNC error after one wait
    head(4'b0010, 32'h03F8, 4);
    nib(1'b1, 4'hA); nib(1'b1, 4'h5);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    nib(1'b1, 4'h5);
    nib(1'b1, 4'hA); push(4'b0010, 32'h3F8, 8'h5A, 3'd1, 5'd1, 1'b1);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // abort during address phase of a memory read: reported only with abort reporting on
    head(4'b0100, 32'h123, 3);
    nib(1'b0, 4'hF); push(4'b0100, 32'h123, 8'h00, 3'd3, 5'd0, 1'b0);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // DMA cycle: silently dropped
    head(4'b1000, 32'h1234, 4);
    nib(1'b1, 4'hF); nib(1'b1, 4'h0); nib(1'b1, 4'h5); nib(1'b1, 4'hF);
    // illegal SYNC nibble
    head(4'b0000, 32'h1234, 4);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    nib(1'b1, 4'h3); push(4'b0000, 32'h1234, 8'h00, 3'd4, 5'd0, 1'b1);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // back-to-back I/O reads, second START on the first TAR2 clock
    head(4'b0000, 32'h0060, 4);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'h0);
    nib(1'b1, 4'h7); nib(1'b1, 4'h1); push(4'b0000, 32'h60, 8'h17, 3'd0, 5'd0, 1'b1);
    head(4'b0000, 32'h0064, 4);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'h0);
    nib(1'b1, 4'hE); nib(1'b1, 4'hD); push(4'b0000, 32'h64, 8'hDE, 3'd0, 5'd0, 1'b1);
    nib(1'b1, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
    // reset in the middle of an address phase
    head(4'b0000, 32'h12, 2);
    @(posedge clk);
    rst_n = 1'b0;
    frame = 1'b1;
    ad = 4'hF;
    @(posedge clk);
    check_zero("midreset");
    @(posedge clk);
    rst_n = 1'b1;
    repeat (6) nib(1'b1, 4'hF);
    check("r1_missing_pulses", q1.size(), 0);
    check("r0_missing_pulses", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lpc_cycle_decoder.md
Name: lpc_cycle_decoder

Overview:
- Next-generation LPC bus snooper.
- Decodes I/O and memory read/write cycles from the 4-bit LPC bus and follows them through TAR, SYNC (including wait states), data and the trailing TAR.
- Presents each completed or terminated cycle as a one-clock `out_valid` pulse with a completion status.
- Sits between the LPC pins and the capture FIFO/UART of the sniffer.

Parameters:
- WAIT_MAX, 16, maximum number of wait SYNC nibbles (0101/0110) accepted before the cycle is declared timed out.
- WAIT_CNT_W, 5, width of the wait counter and `out_waits`; must hold WAIT_MAX.
- REPORT_ABORT, 1, when 1 an abort inside a decoded cycle produces an `out_valid` pulse with status ABORT; when 0 it silently returns to IDLE.

Ports:
- lpc_clock  in  1  LPC clock; all logic samples on the falling edge.
- lpc_reset  in  1  asynchronous, active-low reset.
- lpc_ad  in  4  LPC AD[3:0].
- lpc_frame  in  1  LPC FRAME#, active low.
- out_valid  out  1  one-clock pulse: the output fields below are valid.
- out_cyctype_dir  out  4  CYCTYPE+DIR nibble as on the bus (bits[3:2] type, bit1 direction, 1 = write).
- out_addr  out  32  cycle address; bits[31:16] are 0 for I/O cycles.
- out_data  out  8  data byte; 0 when status is not OK/SYNC_ERR.
- out_status  out  3  0 OK, 1 SYNC_ERR (1010 received), 2 TIMEOUT, 3 ABORT, 4 PROTO (illegal SYNC nibble).
- out_waits  out  WAIT_CNT_W  number of wait nibbles seen in SYNC, saturating at WAIT_MAX.

Behaviour:
- Clocking and reset: single clock `lpc_clock`, falling-edge sampling. Reset `lpc_reset` is asynchronous and active-low. During reset the state is IDLE and every output is 0.
- States: IDLE, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2.
- Override rule, evaluated in any state: `lpc_frame`=0 with AD=0000 goes to CYCTYPE. This covers repeated START clocks (the last one wins) and a restart mid-cycle.
- Abort: `lpc_frame`=0 with AD=1111 goes to IDLE. If a cycle was past CYCTYPE and REPORT_ABORT=1, emit status ABORT.
- Any other nibble with `lpc_frame`=0 goes to IDLE, no report.
- CYCTYPE: latch AD.
  - Type 00 (I/O): ADDR with 4 nibbles.
  - Type 01 (memory): ADDR with 8 nibbles.
  - Types 10 and 11 (DMA, reserved): IDLE, no report.
- ADDR: nibbles arrive MSB first and are shifted into `addr`.
  - After the last nibble, a write goes to WDATA and a read goes to TAR1.
- WDATA: 2 nibbles, low nibble first (`data[3:0]` then `data[7:4]`), then TAR1.
- TAR1: exactly 2 clocks, AD ignored, then SYNC. Clear the wait counter.
- SYNC:
  - 0101 or 0110: increment the wait counter and stay. When the counter would exceed WAIT_MAX, report TIMEOUT and go to IDLE.
  - 0000 (OK) or 1010 (SYNC_ERR): a read goes to RDATA; a write reports immediately and goes to TAR2.
  - Any other nibble: report PROTO, go to IDLE.
- RDATA: 2 nibbles, low nibble first. On the clock after the second nibble, report with the status latched in SYNC, then go to TAR2.
- TAR2: 2 clocks, then IDLE. No report is generated here.
- Reporting:
  - `out_valid` is high for exactly one clock, registered, on the falling edge following the terminating nibble.
  - Latency: 1 clock after the last consumed nibble.
  - All other outputs hold their last reported value between pulses.
- Simultaneous events: the override rule has priority over report generation, except that a report already due in that clock is still emitted. Example: a final read nibble sampled, then START on the next clock gives `out_valid` plus the transition to CYCTYPE.
- Reset mid-cycle: immediate IDLE, outputs cleared, no report.
- `out_waits` reports the saturated count; WAIT_MAX waits followed by 0000 is legal.

Decomposition:
- Shared package `lpc_pkg` holds:
  - the state enum;
  - cycle type constants (CT_IO=2'b00, CT_MEM=2'b01);
  - SYNC codes (READY 0000, SHORT 0101, LONG 0110, ERR 1010);
  - START codes (0000, ABORT 1111);
  - the status encodings.
- One natural sub-module, `lpc_sync_tracker`: wait counter, timeout compare and SYNC classification. It outputs done/status/waits to the main FSM.

Test Plan:
- I/O write 0x0080 data 0xA5: START 0000, CT 0010, addr 0,0,8,0, data 5,A, TAR×2, SYNC 0000 → `out_valid` with cyctype 0010, addr 0x00000080, data 0xA5, status 0, waits 0.
- Memory read 0xFFFFFFF0 with 3 short waits (0101×3, then 0000), data nibbles 3,C → addr 0xFFFFFFF0, data 0xC3, status 0, waits 3.
- I/O read where SYNC stays 0110 for WAIT_MAX+1 clocks → one pulse, status 2 (TIMEOUT), waits 16, FSM back in IDLE.
- `lpc_frame` low with AD 1111 during ADDR of a memory read → status 3 (ABORT) with REPORT_ABORT=1; no pulse with REPORT_ABORT=0.
- DMA cycle (CT 1000), and SYNC nibble 0011 in an I/O read → no pulse for the DMA cycle; status 4 (PROTO) for the illegal SYNC.
- Two back-to-back I/O reads with START on the first TAR2 clock, plus `lpc_reset` asserted mid-ADDR → both reads reported; reset clears all outputs to 0 and produces no pulse.
